// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register for the 16-bit five-stage CPU.
// Captures the EX-stage result one cycle later for the memory stage.
// Holds its contents on stall and loads a bubble on flush.
// Registers a MEM-to-MEM forwarding select for a store that directly follows
// a load to its data register.
// Keeps a saturating debug count of honoured stall cycles.
module ex_mem_latch #(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_alu_out,
  input  logic [DW-1:0] ex_store_data,
  input  logic [RW-1:0] ex_rt,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_memenable,
  input  logic          ex_memwrite,
  input  logic          ex_regwrite,
  input  logic          ex_memtoreg,
  input  logic          ex_halt,
  output logic          mem_valid,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_memdata,
  output logic [RW-1:0] mem_rd,
  output logic          mem_memenable,
  output logic          mem_memwrite,
  output logic          mem_regwrite,
  output logic          mem_memtoreg,
  output logic          mem_halt,
  output logic          forward_mm,
  output logic [CW-1:0] stall_count
);

  logic          r_valid;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_memdata;
  logic [RW-1:0] r_rd;
  logic          r_memenable;
  logic          r_memwrite;
  logic          r_regwrite;
  logic          r_memtoreg;
  logic          r_halt;
  logic          r_forward_mm;
  logic [CW-1:0] r_stall_count;

  logic          w_store_in;
  logic          w_load_held;
  logic          w_forward_mm;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // The held instruction is a register-writing load; the incoming one is a
  // valid store. Both move forward on the same edge, so the load ends up in
  // WB while the store is in MEM. r0 is never a real data source.
  assign w_store_in   = ex_valid & ex_memenable & ex_memwrite;
  assign w_load_held  = r_valid & r_memtoreg & r_regwrite;
  assign w_forward_mm = w_store_in & w_load_held & (r_rd == ex_rt) & (ex_rt != '0);

  // Pipeline register update with priority rst > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_addr        <= '0;
      r_memdata     <= '0;
      r_rd          <= '0;
      r_memenable   <= 1'b0;
      r_memwrite    <= 1'b0;
      r_regwrite    <= 1'b0;
      r_memtoreg    <= 1'b0;
      r_halt        <= 1'b0;
      r_forward_mm  <= 1'b0;
      r_stall_count <= '0;
    end else if (flush) begin
      r_valid       <= 1'b0;
      r_addr        <= '0;
      r_memdata     <= '0;
      r_rd          <= '0;
      r_memenable   <= 1'b0;
      r_memwrite    <= 1'b0;
      r_regwrite    <= 1'b0;
      r_memtoreg    <= 1'b0;
      r_halt        <= 1'b0;
      r_forward_mm  <= 1'b0;
    end else if (stall) begin
      r_stall_count <= sat_inc(r_stall_count);
    end else begin
      r_valid       <= ex_valid;
      r_addr        <= ex_alu_out;
      r_memdata     <= ex_store_data;
      r_rd          <= ex_rd;
      r_memenable   <= ex_memenable & ex_valid;
      r_memwrite    <= ex_memwrite  & ex_valid;
      r_regwrite    <= ex_regwrite  & ex_valid;
      r_memtoreg    <= ex_memtoreg  & ex_valid;
      r_halt        <= ex_halt      & ex_valid;
      r_forward_mm  <= w_forward_mm;
    end
  end

  assign mem_valid     = r_valid;
  assign mem_addr      = r_addr;
  assign mem_memdata   = r_memdata;
  assign mem_rd        = r_rd;
  assign mem_memenable = r_memenable;
  assign mem_memwrite  = r_memwrite;
  assign mem_regwrite  = r_regwrite;
  assign mem_memtoreg  = r_memtoreg;
  assign mem_halt      = r_halt;
  assign forward_mm    = r_forward_mm;
  assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Randomised scoreboard bench for ex_mem_latch: a driver issues one stimulus
// per cycle and queues the expected outputs from a behavioural model; a
// monitor pops and compares after each rising edge. A second instance with a
// 4-bit counter checks stall-count saturation.
module tb_ex_mem_latch;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        valid;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [3:0]  rt;
    logic [3:0]  rd;
    logic        me;
    logic        mw;
    logic        rw;
    logic        mtr;
    logic        halt;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  rd;
    logic        me;
    logic        mw;
    logic        rw;
    logic        mtr;
    logic        halt;
    logic        fwd;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, ex_valid;
  logic [15:0] ex_alu_out, ex_store_data;
  logic [3:0]  ex_rt, ex_rd;
  logic        ex_memenable, ex_memwrite, ex_regwrite, ex_memtoreg, ex_halt;

  logic        mem_valid, mem_memenable, mem_memwrite, mem_regwrite, mem_memtoreg, mem_halt, forward_mm;
  logic [15:0] mem_addr, mem_memdata;
  logic [3:0]  mem_rd;
  logic [15:0] stall_count;

  logic        s_valid, s_memenable, s_memwrite, s_regwrite, s_memtoreg, s_halt, s_forward_mm;
  logic [15:0] s_addr, s_memdata;
  logic [3:0]  s_rd;
  logic [3:0]  s_stall_count;

  ex_mem_latch #(.DW(16), .RW(4), .CW(16)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_memenable(ex_memenable), .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_halt(ex_halt),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_memdata(mem_memdata), .mem_rd(mem_rd),
    .mem_memenable(mem_memenable), .mem_memwrite(mem_memwrite), .mem_regwrite(mem_regwrite),
    .mem_memtoreg(mem_memtoreg), .mem_halt(mem_halt), .forward_mm(forward_mm),
    .stall_count(stall_count)
  );

  ex_mem_latch #(.DW(16), .RW(4), .CW(4)) u_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_memenable(ex_memenable), .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_halt(ex_halt),
    .mem_valid(s_valid), .mem_addr(s_addr), .mem_memdata(s_memdata), .mem_rd(s_rd),
    .mem_memenable(s_memenable), .mem_memwrite(s_memwrite), .mem_regwrite(s_regwrite),
    .mem_memtoreg(s_memtoreg), .mem_halt(s_halt), .forward_mm(s_forward_mm),
    .stall_count(s_stall_count)
  );

  // Scoreboard queues and reference model state.
  exp_t     q_exp[$];
  int       q_cnt4[$];
  exp_t     m;
  int       m_stalls;
  int       n_vec = 0;
  int       n_err = 0;
  int       cyc = 0;

  // Reference model: what the latch should hold after one edge with stimulus s.
  task automatic apply(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst = s.rst; stall = s.stall; flush = s.flush; ex_valid = s.valid;
    ex_alu_out = s.alu; ex_store_data = s.sd; ex_rt = s.rt; ex_rd = s.rd;
    ex_memenable = s.me; ex_memwrite = s.mw; ex_regwrite = s.rw;
    ex_memtoreg = s.mtr; ex_halt = s.halt;
    e = m;
    if (s.rst) begin
      e = '0;
      m_stalls = 0;
    end else if (s.flush) begin
      e = '0;
      e.cnt = m.cnt;
    end else if (s.stall) begin
      m_stalls = m_stalls + 1;
      e.cnt = (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls);
    end else begin
      e.fwd   = s.valid && s.me && s.mw && m.valid && m.mtr && m.rw
                && (m.rd == s.rt) && (s.rt != 4'd0);
      e.valid = s.valid;
      e.addr  = s.alu;
      e.data  = s.sd;
      e.rd    = s.rd;
      e.me    = s.me  && s.valid;
      e.mw    = s.mw  && s.valid;
      e.rw    = s.rw  && s.valid;
      e.mtr   = s.mtr && s.valid;
      e.halt  = s.halt && s.valid;
    end
    m = e;
    q_exp.push_back(e);
    q_cnt4.push_back((m_stalls > 15) ? 15 : m_stalls);
  endtask

  // Monitor: compare every queued expectation just after the edge it describes.
  always @(posedge clk) begin
    exp_t a, e, b;
    int   c4;
    #1;
    cyc++;
    if (q_exp.size() != 0) begin
      e  = q_exp.pop_front();
      c4 = q_cnt4.pop_front();
      a = {mem_valid, mem_addr, mem_memdata, mem_rd, mem_memenable, mem_memwrite,
           mem_regwrite, mem_memtoreg, mem_halt, forward_mm, stall_count};
      b = {s_valid, s_addr, s_memdata, s_rd, s_memenable, s_memwrite,
           s_regwrite, s_memtoreg, s_halt, s_forward_mm, e.cnt};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs cyc=%0d got v=%b a=%h d=%h rd=%h me=%b mw=%b rw=%b mtr=%b h=%b fwd=%b cnt=%0d want v=%b a=%h d=%h rd=%h me=%b mw=%b rw=%b mtr=%b h=%b fwd=%b cnt=%0d",
                 cyc, a.valid, a.addr, a.data, a.rd, a.me, a.mw, a.rw, a.mtr, a.halt, a.fwd, a.cnt,
                 e.valid, e.addr, e.data, e.rd, e.me, e.mw, e.rw, e.mtr, e.halt, e.fwd, e.cnt);
      end
      n_vec++;
      if (b !== e) begin
        n_err++;
        $display("FAIL cw4_outputs cyc=%0d got %h want %h", cyc, b, e);
      end
      n_vec++;
      if (int'(s_stall_count) != c4) begin
        n_err++;
        $display("FAIL sat_count cyc=%0d got %0d want %0d", cyc, s_stall_count, c4);
      end
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rnd(input int p_stall, input int p_flush);
    stim_t s;
    s.rst   = ($urandom_range(99) < 2);
    s.stall = ($urandom_range(99) < p_stall);
    s.flush = ($urandom_range(99) < p_flush);
    s.valid = ($urandom_range(99) < 85);
    s.alu   = 16'($urandom);
    s.sd    = 16'($urandom);
    s.rt    = 4'($urandom_range(3));
    s.rd    = 4'($urandom_range(3));
    s.me    = 1'($urandom);
    s.mw    = 1'($urandom);
    s.rw    = 1'($urandom);
    s.mtr   = 1'($urandom);
    s.halt  = ($urandom_range(99) < 10);
    return s;
  endfunction

  function automatic stim_t ld(input logic [3:0] rd);
    stim_t s;
    s = '0;
    s.valid = 1'b1; s.rd = rd; s.me = 1'b1; s.rw = 1'b1; s.mtr = 1'b1;
    s.alu = 16'h0040; s.rt = 4'd7;
    return s;
  endfunction

  function automatic stim_t st(input logic [3:0] rt);
    stim_t s;
    s = '0;
    s.valid = 1'b1; s.rt = rt; s.me = 1'b1; s.mw = 1'b1;
    s.alu = 16'h0080; s.sd = 16'hBEEF; s.rd = 4'd9;
    return s;
  endfunction

  initial begin
    stim_t s;
    m = '0;
    m_stalls = 0;

    // Reset for two cycles with every EX input nonzero.
    s = '1;
    s.stall = 1'b0; s.flush = 1'b0;
    apply(s);
    apply(s);
    apply(idle());

    // Basic store passes through.
    s = '0;
    s.valid = 1'b1; s.alu = 16'h00A4; s.sd = 16'h1234; s.rd = 4'd5; s.me = 1'b1; s.mw = 1'b1;
    apply(s);

    // Load r3 then store r3: forward, and keep it through a stall.
    apply(ld(4'd3));
    apply(st(4'd3));
    s = st(4'd3); s.stall = 1'b1;
    apply(s);
    // Different register and r0 never forward; a bubble breaks forwarding.
    apply(ld(4'd3));
    apply(st(4'd4));
    apply(ld(4'd0));
    apply(st(4'd0));
    apply(ld(4'd6));
    apply(idle());
    apply(st(4'd6));

    // Fresh count: three stalls with changing inputs, then stall+flush.
    s = '0; s.rst = 1'b1;
    apply(s);
    apply(st(4'd2));
    for (int i = 0; i < 3; i++) begin
      s = rnd(0, 0); s.rst = 1'b0; s.stall = 1'b1; s.flush = 1'b0;
      apply(s);
    end
    s = st(4'd2); s.stall = 1'b1; s.flush = 1'b1;
    apply(s);

    // Invalid instruction: control outputs gated off.
    s = '1;
    s.rst = 1'b0; s.stall = 1'b0; s.flush = 1'b0; s.valid = 1'b0;
    apply(s);

    // Long stall saturates the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      s = rnd(0, 0); s.rst = 1'b0; s.stall = 1'b1; s.flush = 1'b0;
      apply(s);
    end

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      apply(rnd(20, 8));
    end
    apply(idle());

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && q_exp.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (q_exp.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending want 0", q_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
